// File: rtl/blackjack_pkg.sv
// Shared types, deck constants and card-index helpers for the blackjack card dealer.
// A card index 0..51 encodes suit in idx/13 and rank in idx%13+1.
package blackjack_pkg;

    localparam int DECK_SIZE      = 52;
    localparam int CARDS_PER_SUIT = 13;

    typedef logic [3:0] card_value_t;
    typedef logic [1:0] card_symbol_t;
    typedef logic [5:0] card_idx_t;
    typedef logic [5:0] card_count_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PICK,
        ST_PROBE,
        ST_GRANT
    } dealer_state_e;

    localparam card_count_t FULL_DECK = card_count_t'(DECK_SIZE);
    localparam card_idx_t   LAST_IDX  = card_idx_t'(DECK_SIZE - 1);

    // Six random bits cover 0..63; the top twelve values wrap back onto the deck.
    function automatic card_idx_t fold_idx(input logic [5:0] raw);
        if (raw >= card_idx_t'(DECK_SIZE)) begin
            return raw - card_idx_t'(DECK_SIZE);
        end
        return raw;
    endfunction

    function automatic card_symbol_t idx_to_symbol(input card_idx_t idx);
        if (idx >= card_idx_t'(3 * CARDS_PER_SUIT)) begin
            return 2'd3;
        end else if (idx >= card_idx_t'(2 * CARDS_PER_SUIT)) begin
            return 2'd2;
        end else if (idx >= card_idx_t'(CARDS_PER_SUIT)) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

    function automatic card_value_t idx_to_value(input card_idx_t idx);
        card_idx_t rank;
        rank = idx - card_idx_t'(CARDS_PER_SUIT) * card_idx_t'(idx_to_symbol(idx)) + card_idx_t'(1);
        return card_value_t'(rank);
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the shuffle entropy source.
// A zero seed would lock the register at zero, so it is replaced by a known non-zero value.
module card_lfsr (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [15:0] seed_safe;
    logic        feedback;

    always_comb begin
        feedback  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d    = {lfsr_q[14:0], feedback};
        seed_safe = (seed == 16'h0000) ? 16'hACE1 : seed;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= seed_safe;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/card_dealer.sv
// Deals random cards without replacement to a player and a dealer requester,
// arbitrating round-robin and probing a used-card mask linearly from a random start.
module card_dealer
    import blackjack_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shuffle,
    input  logic               player_req,
    input  logic               dealer_req,
    output logic               player_ack,
    output logic               dealer_ack,
    output logic         [3:0] card_value,
    output logic         [1:0] card_symbol,
    output logic         [5:0] cards_left,
    output logic               deck_empty,
    output logic               busy
);

    dealer_state_e            state_q, state_d;
    card_idx_t                idx_q, idx_d;
    logic [DECK_SIZE-1:0]     used_q, used_d;
    card_count_t              left_q, left_d;
    card_value_t              value_q, value_d;
    card_symbol_t             symbol_q, symbol_d;
    logic                     player_ack_q, player_ack_d;
    logic                     dealer_ack_q, dealer_ack_d;
    logic                     winner_q, winner_d;
    logic                     prio_dealer_q, prio_dealer_d;
    logic                     winner_req;
    logic [15:0]              lfsr_state;
    logic                     lfsr_unused;

    card_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (LFSR_SEED),
        .state (lfsr_state)
    );

    assign lfsr_unused = ^lfsr_state[15:6];

    // winner_q: 1 means the dealer owns the in-flight request.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        used_d        = used_q;
        left_d        = left_q;
        value_d       = value_q;
        symbol_d      = symbol_q;
        player_ack_d  = 1'b0;
        dealer_ack_d  = 1'b0;
        winner_d      = winner_q;
        prio_dealer_d = prio_dealer_q;
        winner_req    = winner_q ? dealer_req : player_req;

        case (state_q)
            ST_IDLE: begin
                if ((player_req || dealer_req) && (left_q != card_count_t'(0))) begin
                    state_d  = ST_PICK;
                    winner_d = (player_req && dealer_req) ? prio_dealer_q : dealer_req;
                end
            end
            ST_PICK: begin
                if (!winner_req) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = fold_idx(lfsr_state[5:0]);
                    state_d = ST_PROBE;
                end
            end
            ST_PROBE: begin
                if (!winner_req) begin
                    state_d = ST_IDLE;
                end else if (used_q[idx_q]) begin
                    idx_d = (idx_q == LAST_IDX) ? card_idx_t'(0) : idx_q + card_idx_t'(1);
                end else begin
                    state_d        = ST_GRANT;
                    used_d[idx_q]  = 1'b1;
                    left_d         = left_q - card_count_t'(1);
                    value_d        = idx_to_value(idx_q);
                    symbol_d       = idx_to_symbol(idx_q);
                    player_ack_d   = ~winner_q;
                    dealer_ack_d   = winner_q;
                    prio_dealer_d  = ~winner_q;
                end
            end
            ST_GRANT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A shuffle discards any grant being prepared this cycle, card outputs included.
        if (shuffle) begin
            state_d       = ST_IDLE;
            used_d        = '0;
            left_d        = FULL_DECK;
            value_d       = value_q;
            symbol_d      = symbol_q;
            player_ack_d  = 1'b0;
            dealer_ack_d  = 1'b0;
            prio_dealer_d = prio_dealer_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            used_q        <= '0;
            left_q        <= FULL_DECK;
            value_q       <= '0;
            symbol_q      <= '0;
            player_ack_q  <= 1'b0;
            dealer_ack_q  <= 1'b0;
            winner_q      <= 1'b0;
            prio_dealer_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            used_q        <= used_d;
            left_q        <= left_d;
            value_q       <= value_d;
            symbol_q      <= symbol_d;
            player_ack_q  <= player_ack_d;
            dealer_ack_q  <= dealer_ack_d;
            winner_q      <= winner_d;
            prio_dealer_q <= prio_dealer_d;
        end
    end

    assign player_ack  = player_ack_q;
    assign dealer_ack  = dealer_ack_q;
    assign card_value  = value_q;
    assign card_symbol = symbol_q;
    assign cards_left  = left_q;
    assign deck_empty  = (left_q == card_count_t'(0));
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1, the non-zero LFSR reset value.
REQ-002 SHALL have port clk  in  1  posedge clock, the only clock.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port shuffle  in  1  one-cycle pulse that returns all 52 cards to the deck.
REQ-005 SHALL have port player_req  in  1  player FSM card request; held high until player_ack.
REQ-006 SHALL have port dealer_req  in  1  dealer FSM card request; held high until dealer_ack.
REQ-007 SHALL have port player_ack  out  1  one-cycle pulse: card outputs are valid for the player.
REQ-008 SHALL have port dealer_ack  out  1  one-cycle pulse: card outputs are valid for the dealer.
REQ-009 SHALL have port card_value  out  4  dealt rank, 1..13.
REQ-010 SHALL have port card_symbol  out  2  dealt suit, 0..3.
REQ-011 SHALL have port cards_left  out  6  cards remaining in the deck, 0..52.
REQ-012 SHALL have port deck_empty  out  1  high while cards_left==0.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-014 SHALL advance a 16-bit Fibonacci LFSR every clock (taps 16,14,13,11); its state SHALL never be zero.
REQ-015 SHALL hold a 52-bit used mask; card index i maps to value i%13+1 and symbol i/13.
REQ-016 SHALL implement states IDLE, PICK, PROBE, GRANT.
REQ-017 IDLE->PICK SHALL occur when any req is high and deck_empty==0; the winner SHALL be latched.
REQ-018 Arbitration SHALL be round-robin: on simultaneous requests, the side not granted last wins; after reset, player wins.
REQ-019 PICK SHALL register idx = lfsr[5:0], minus 52 if >=52, then go to PROBE.
REQ-020 PROBE SHALL go to GRANT if used[idx]==0; otherwise idx = (idx+1) mod 52 and stay in PROBE, 1 cycle per probe.
REQ-021 GRANT SHALL:
- set used[idx] and decrement cards_left;
- register card_value and card_symbol;
- pulse the winner's ack for exactly 1 cycle, then return to IDLE.
REQ-022 Latency SHALL be: req first seen in IDLE at cycle N gives ack high at cycle N+3+k, where k is the number of occupied probes (k<=51).
REQ-023 card_value and card_symbol SHALL hold their value until the next grant.
REQ-024 If the latched requester drops req before GRANT, the FSM SHALL return to IDLE with no ack and no card consumed.
REQ-025 While deck_empty, requests SHALL be ignored: no ack, FSM stays in IDLE.
REQ-026 shuffle SHALL act in any state, taking priority over everything else:
- clear used, set cards_left=52;
- abort any in-flight request with no ack; state becomes IDLE next cycle.
REQ-027 An aborted requester still holding req SHALL be re-arbitrated from IDLE.
REQ-028 player_ack and dealer_ack SHALL never be high in the same cycle.

Reset
REQ-029 On rst the block SHALL set: state=IDLE, used=0, cards_left=52, lfsr=LFSR_SEED, both acks=0, card_value=0, card_symbol=0, round-robin pointer to player.
REQ-030 rst SHALL override shuffle and all requests, including a reset asserted mid-operation.

Structure
REQ-031 blackjack_pkg SHALL hold: card_value_t (4b), card_symbol_t (2b), DECK_SIZE=52, CARDS_PER_SUIT=13, and the dealer state enum.
REQ-032 The LFSR SHALL be the sub-module card_lfsr (clk, rst, seed, 16-bit state out).

Verification
REQ-033 Reset, then player_req alone -> player_ack at cycle N+3, cards_left=51, card_value in 1..13.
REQ-034 player_req and dealer_req together, repeated -> grants alternate P,D,P,D; never both acks in one cycle.
REQ-035 52 sequential requests -> 52 distinct (value,symbol) pairs; deck_empty=1 and cards_left=0; a 53rd request -> no ack within 100 cycles.
REQ-036 shuffle pulsed during PROBE -> no ack for that request, cards_left=52, request re-served afterwards.
REQ-037 dealer_req dropped in PICK -> no dealer_ack, cards_left unchanged.
REQ-038 rst asserted during GRANT -> cycle after: acks 0, cards_left=52, card_value=0.
